// File: rtl/module_bcd_display_ctrl_pkg.sv
// Shared types and constants for the BCD display controller.
package pkg_bcd_display;

    localparam int unsigned BIN_W  = 12;
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StCommit
    } state_e;

endpackage

// File: rtl/module_bcd_display_ctrl_seg7_decoder.sv
// BCD nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles blank.
module module_seg7_decoder
    import pkg_bcd_display::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Segment lookup with forced blank override.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            unique case (bcd_i)
                4'd0:    seg_o = 7'b1000000;
                4'd1:    seg_o = 7'b1111001;
                4'd2:    seg_o = 7'b0100100;
                4'd3:    seg_o = 7'b0110000;
                4'd4:    seg_o = 7'b0011001;
                4'd5:    seg_o = 7'b0010010;
                4'd6:    seg_o = 7'b0000010;
                4'd7:    seg_o = 7'b1111000;
                4'd8:    seg_o = 7'b0000000;
                4'd9:    seg_o = 7'b0010000;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/module_bcd_display_ctrl.sv
// Binary-to-BCD converter (shift-add-3, one shift per clock) with a multiplexed
// 4-digit common-anode 7-segment scanner driven from the committed result.
module module_bcd_display_ctrl
    import pkg_bcd_display::*;
#(
    parameter int unsigned REFRESH_DIV   = 27000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [BIN_W-1:0] i_bin,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_bcd_valid,
    output logic [DIGITS-1:0] o_anodes,
    output logic [6:0]       o_segments
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic [BCD_W-1:0]   corr;

    logic [CntW-1:0]    refresh_q;
    logic [1:0]         idx_q;
    logic [DIGITS-1:0]  anodes_q;
    logic [6:0]         segments_q;
    logic [3:0]         sel_nib;
    logic               sel_blank;
    logic [6:0]         seg_next;
    logic               refresh_wrap;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (i_valid) state_d = StConv;
            StConv:   if (cnt_q == 4'd11) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        o_ready = (state_q == StIdle);
    end

    // Add-3 correction on every nibble, all judged on pre-correction values.
    always_comb begin
        corr = scratch_q;
        for (int n = 0; n < 4; n++) begin
            if (scratch_q[4*n +: 4] >= 4'd5) corr[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
        end
    end

    // Conversion datapath next-state.
    always_comb begin
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    shift_d   = i_bin;
                    scratch_d = '0;
                    cnt_d     = 4'd0;
                end
            end
            StConv: begin
                scratch_d = {corr[BCD_W-2:0], shift_q[BIN_W-1]};
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q + 4'd1;
            end
            StCommit: begin
                bcd_d       = scratch_q;
                bcd_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Conversion datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= 4'd0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign refresh_wrap = (refresh_q == CntW'(REFRESH_DIV - 1));

    // Select the nibble for the current digit and decide leading-zero blanking.
    always_comb begin
        sel_nib   = bcd_q[3:0];
        sel_blank = 1'b0;
        unique case (idx_q)
            2'd0: sel_nib = bcd_q[3:0];
            2'd1: begin
                sel_nib   = bcd_q[7:4];
                sel_blank = BLANK_LEADING && (bcd_q[15:4] == 12'd0);
            end
            2'd2: begin
                sel_nib   = bcd_q[11:8];
                sel_blank = BLANK_LEADING && (bcd_q[15:8] == 8'd0);
            end
            2'd3: begin
                sel_nib   = bcd_q[15:12];
                sel_blank = BLANK_LEADING && (bcd_q[15:12] == 4'd0);
            end
            default: ;
        endcase
    end

    module_seg7_decoder u_dec (
        .bcd_i   (sel_nib),
        .blank_i (sel_blank),
        .seg_o   (seg_next)
    );

    // Scan counter, digit index, and anode/segment registers updated together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            refresh_q  <= '0;
            idx_q      <= 2'd0;
            anodes_q   <= 4'b1110;
            segments_q <= SEG_ZERO;
        end else begin
            refresh_q  <= refresh_wrap ? '0 : refresh_q + CntW'(1);
            if (refresh_wrap) idx_q <= idx_q + 2'd1;
            anodes_q   <= ~(4'b0001 << idx_q);
            segments_q <= seg_next;
        end
    end

    assign o_bcd       = bcd_q;
    assign o_bcd_valid = bcd_valid_q;
    assign o_anodes    = anodes_q;
    assign o_segments  = segments_q;

endmodule

// File: doc/module_bcd_display_ctrl.md
Name: module_bcd_display_ctrl

Overview:
Sequential controller that accepts a 12-bit binary value over a valid/ready handshake. It converts the value to 4-digit BCD with an iterative shift-add-3 sequence, one shift per clock, and commits the result to a holding register. It also time-multiplexes the committed BCD onto a 4-digit common-anode 7-segment display, with optional leading-zero blanking. It sits between the measurement/arithmetic datapath and the board display pins.

Parameters:
REFRESH_DIV, 27000, clock cycles each digit stays active (1 kHz per digit at 27 MHz); minimum 2.
BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = show all four digits.

Ports:
i_clk  in  1  system clock; single clock domain.
i_rst  in  1  reset, synchronous, active-high.
i_valid  in  1  i_bin is valid.
o_ready  out  1  controller idle and able to accept.
i_bin  in  12  binary value, 0..4095.
o_bcd  out  16  committed BCD result; [3:0]=units ... [15:12]=thousands.
o_bcd_valid  out  1  one-cycle pulse when o_bcd is updated.
o_anodes  out  4  active-low one-hot digit enable; bit0 = units.
o_segments  out  7  active-low segments, order {g,f,e,d,c,b,a}.

Behaviour:
- Reset values (all synchronous on i_clk with i_rst=1):
  - state IDLE, o_bcd=16'h0000, o_bcd_valid=0.
  - Refresh counter=0, digit index=0.
  - o_anodes=4'b1110, o_segments=7'b1000000 (digit "0").
- o_ready = (state==IDLE), decoded from the state register.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: on an edge with i_valid & o_ready, latch i_bin into the shift register, clear the 16-bit scratch, set shift count=0, go to CONV.
  - CONV: each edge, add 3 to every scratch nibble >=5 (all four nibbles evaluated on pre-correction values), then shift {scratch, shift_reg} left by 1 and increment count. The edge performing shift 12 (count==11) moves to COMMIT.
  - COMMIT: one edge loads o_bcd<=scratch, pulses o_bcd_valid=1 for exactly one cycle, and returns to IDLE.
- Latency and throughput:
  - Accept at edge k; shifts at edges k+1..k+12; commit at edge k+13.
  - o_bcd_valid and o_ready are both high in the cycle after edge k+13.
  - One conversion per 14 cycles.
- i_valid while not ready is ignored; no queuing. The upstream holds or drops the value.
- The scratch and shift registers are internal only. o_bcd changes only at COMMIT, so the display never shows intermediate values.
- Arithmetic: the scratch is 16 bits; the maximum input 4095 gives 16'h4095, so no overflow is possible.
- Reset mid-conversion aborts: no o_bcd_valid pulse, o_bcd=0, ready again in the first cycle after reset deasserts.
- Display scan:
  - Free-running refresh counter runs 0..REFRESH_DIV-1.
  - At wrap, the digit index advances 0->1->2->3->0. The scan is independent of the FSM.
  - o_anodes = ~(1<<index), registered.
  - o_segments = decode(o_bcd nibble[index]), registered in the same edge as o_anodes so there is no ghosting skew.
- Decode (active-low {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles 10-15 decode to blank 1111111.
- Leading-zero blanking (BLANK_LEADING=1): digit i>0 shows blank 1111111 when nibble i and every higher nibble are zero. The units digit is never blanked; the anode still cycles.
- If o_bcd changes mid-scan, the new value appears from the next digit refresh.

Decomposition:
- Package pkg_bcd_display:
  - state enum {IDLE, CONV, COMMIT}.
  - Constants: BIN_W=12, BCD_W=16, DIGITS=4, SEG_BLANK=7'b1111111, digit-0 reset pattern 7'b1000000.
- Sub-module module_seg7_decoder: combinational 4-bit BCD + blank -> 7-bit active-low segments, instantiated once on the selected nibble.

Test Plan:
- Reset, then i_bin=1234 with i_valid for one cycle -> accepted; o_bcd_valid pulses exactly 13 edges after the accept edge; o_bcd=16'h1234; o_ready low for 13 cycles.
- i_bin=4095 -> o_bcd=16'h4095. i_bin=0 -> o_bcd=16'h0000; display shows only the units "0" (1000000), digits 1-3 blank.
- Second i_valid pulse with i_bin=99 during CONV -> ignored; o_bcd keeps the first result; exactly one o_bcd_valid pulse.
- Assert i_rst for one cycle after 6 shifts of i_bin=2048 -> no o_bcd_valid pulse; o_bcd=0; o_ready=1 the cycle after reset releases; a new 2048 then yields 16'h2048.
- REFRESH_DIV=4, o_bcd=16'h0907:
  - o_anodes cycles 1110, 1101, 1011, 0111, each for 4 cycles.
  - Segments per digit: 1111000 (7), 1000000 (0), 0010000 (9), 1111111 (blank thousands).
  - With BLANK_LEADING=0, the thousands digit shows 1000000.
- i_valid held high continuously with changing i_bin -> accepts exactly every 14 cycles; each o_bcd matches the value sampled at its accept edge.
